// File: rtl/rr_mux_arbiter8.sv
// Round-robin arbiter sharing one 8:1 data mux between eight requesters,
// with a valid/ready output handshake and a per-grant burst limit.

module mux8x1 #(
  parameter int unsigned size = 8
) (
  input  logic [size*8-1:0] inputVal,
  input  logic [2:0]        sel,
  output logic [size-1:0]   y
);

  assign y = inputVal[sel*size +: size];

endmodule

module rr_mux_arbiter8 #(
  parameter int unsigned size     = 8,
  parameter int unsigned maxBurst = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req,
  input  logic [size*8-1:0] inputVal,
  input  logic              outReady,
  output logic [7:0]        gnt,
  output logic [2:0]        sel,
  output logic [size-1:0]   y,
  output logic              outValid,
  output logic              xfer
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(maxBurst - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic [2:0] r_rrPtr, w_rrPtr_nxt;
  logic [7:0] r_beatCnt, w_beatCnt_nxt;

  logic       w_found;
  logic [2:0] w_win;
  logic [2:0] w_idx;
  logic       w_valid;
  logic       w_xfer;

  mux8x1 #(.size(size)) u_mux (
    .inputVal (inputVal),
    .sel      (r_sel),
    .y        (y)
  );

  assign w_valid  = (r_state == GRANT) && req[r_sel];
  assign w_xfer   = w_valid && outReady;
  assign outValid = w_valid;
  assign xfer     = w_xfer;
  assign gnt      = r_gnt;
  assign sel      = r_sel;

  // Priority search starting at rrPtr; 3-bit addition supplies the 7->0 wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_idx = r_rrPtr + 3'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_rrPtr_nxt   = r_rrPtr;
    w_beatCnt_nxt = r_beatCnt;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt   = GRANT;
          w_sel_nxt     = w_win;
          w_gnt_nxt     = 8'b1 << w_win;
          w_beatCnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!req[r_sel] || (w_xfer && (r_beatCnt == LAST_BEAT))) begin
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          w_rrPtr_nxt   = r_sel + 3'd1;
          w_beatCnt_nxt = '0;
        end else if (w_xfer) begin
          w_beatCnt_nxt = r_beatCnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_rrPtr   <= '0;
      r_beatCnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_rrPtr   <= w_rrPtr_nxt;
      r_beatCnt <= w_beatCnt_nxt;
    end
  end

endmodule
